traffic_ctrl_n: RTL and testbench
=================================

# traffic_ctrl_n

Parametrised N-way intersection controller with pedestrian walk phases. Each approach gets a timed green, yellow and all-red clearance in round-robin order; pedestrian requests are latched and served in a dedicated all-vehicles-red WALK phase. It is the generalised successor of the fixed 4-way `traffic` controller and drives the same lamp-level outputs, with per-way lamp vectors instead of discrete signals.

## Interface
- `N_WAYS`, 4, number of approaches / crossings, legal 2..8
- `GREEN_CYC`, 8, green duration in clk cycles, ≥1
- `YELLOW_CYC`, 3, yellow duration, ≥1
- `ALLRED_CYC`, 2, all-red clearance after each yellow, ≥1
- `WALK_CYC`, 4, pedestrian walk duration, ≥1
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `en`  in  1  phase-timer advance enable; 0 freezes timer and state
- `ped_req`  in  N_WAYS  pedestrian button per crossing, level or pulse, sampled each edge
- `sig_g` / `sig_y` / `sig_r`  out  N_WAYS each  vehicle lamps per approach
- `ped_g` / `ped_r`  out  N_WAYS each  pedestrian lamps per crossing
- `active_way`  out  $clog2(N_WAYS)  approach currently owning (or last owning) green/yellow
- `ped_pending`  out  N_WAYS  latched, not-yet-served pedestrian requests

## Operation
- States: ALLRED, GREEN, YELLOW, WALK. Timer loads (duration−1) on state entry, decrements when `en`=1, transition taken on the edge where timer==0 and `en`=1.
- GREEN(w) → YELLOW(w) → ALLRED → WALK if `ped_pending`≠0, else GREEN(w+1 mod N_WAYS). WALK → GREEN(w+1 mod N_WAYS). `active_way` updates on entry to GREEN.
- GREEN(w): `sig_g[w]`=1. YELLOW(w): `sig_y[w]`=1. All other approaches red. ALLRED and WALK: all `sig_r`=1.
- WALK: `ped_g[i]`=`ped_pending[i]` as captured on WALK entry (snapshot); all others `ped_r`=1.
- `ped_pending[i]` sets on any edge with `ped_req[i]`=1 (independent of `en`); clears on WALK exit only for bits in the snapshot. Set and clear in same cycle → set wins (stays pending, served next WALK).
- Invariants: at most one bit of `sig_g|sig_y` high; `sig_r`=~(`sig_g`|`sig_y`); `ped_r`=~`ped_g`; `ped_g`≠0 only when all `sig_r`=1.
- Outputs decoded only from registered state/way/snapshot; no combinational path from inputs to lamps.

## Timing
- Reset values: `sig_r`=all 1, `sig_g`=`sig_y`=0, `ped_r`=all 1, `ped_g`=0, `ped_pending`=0, `active_way`=0; state ALLRED, timer ALLRED_CYC−1, next way 0.
- Reset asserted mid-phase: lamps go to reset values asynchronously; pending requests discarded.
- After reset release with `en`=1: ALLRED_CYC cycles all red, then `sig_g[0]` for GREEN_CYC cycles.
- Each phase lasts exactly its duration in `en`=1 cycles; `en`=0 cycles extend the current phase one-for-one.
- `ped_req` at edge k → `ped_pending` visible after edge k.
- Rotation without pedestrians: N_WAYS×(GREEN_CYC+YELLOW_CYC+ALLRED_CYC) cycles.

## Structure
- Package `traffic_pkg`: state enum (ALLRED, GREEN, YELLOW, WALK), default duration constants, timer-width function (max of four durations).
- Sub-module `phase_timer`: load value, enable, down-counter, `done` flag; instantiated once.
- Parameter legality checked by elaboration-time assertion.

## Test plan
- Defaults, no `ped_req`, `en`=1 → after 2 all-red cycles, `sig_g[0]` 8 cycles, `sig_y[0]` 3, all red 2, then `sig_g[1]`; `sig_g[0]` returns 52 cycles after first rise.
- `ped_req[1]` one-cycle pulse during GREEN(0) → `ped_pending`=0010 next cycle; after ALLRED, 4-cycle WALK with `ped_g`=0010, all `sig_r`=1; then `sig_g[1]`, `ped_pending`=0.
- `ped_req[3]` held on last WALK cycle while serving bit 1 → `ped_pending[1]` clears, `ped_pending[3]` remains 1; next WALK shows `ped_g`=1000.
- `en`=0 for 5 cycles inside YELLOW(2) → `sig_y[2]` high 8 cycles total; `ped_req[0]` during freeze still sets `ped_pending[0]`.
- `reset` pulsed asynchronously (between edges) mid-GREEN(2) with pending bits → lamps all red and `ped_pending`=0 before next edge; restart serves way 0 after 2 cycles.
- N_WAYS=2, all durations 1 → `sig_g` alternates 01/10 with 1-cycle yellow and all-red between; invariants checked every cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the N-way intersection controller.
// The timer width is sized to hold the longest phase's (duration - 1).
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    WALK   = 2'd3
  } state_e;

  localparam int DEF_N_WAYS     = 4;
  localparam int DEF_GREEN_CYC  = 8;
  localparam int DEF_YELLOW_CYC = 3;
  localparam int DEF_ALLRED_CYC = 2;
  localparam int DEF_WALK_CYC   = 4;

  function automatic int timer_width(input int g, input int y, input int a, input int w);
    int m;
    m = g;
    if (y > m) m = y;
    if (a > m) m = a;
    if (w > m) m = w;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: loads (duration - 1) on a phase change, counts down
// while enabled and holds at zero; done marks the last cycle of the phase.
module phase_timer #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-way round-robin intersection controller with a shared pedestrian WALK phase.
//   state  | meaning
//   ALLRED | clearance after yellow (and reset state); all vehicle lamps red
//   GREEN  | approach way_q has green
//   YELLOW | approach way_q has yellow
//   WALK   | all vehicles red; crossings in the entry snapshot get ped green
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_WAYS     = DEF_N_WAYS,
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int WALK_CYC   = DEF_WALK_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N_WAYS-1:0]         ped_req,
  output logic [N_WAYS-1:0]         sig_g,
  output logic [N_WAYS-1:0]         sig_y,
  output logic [N_WAYS-1:0]         sig_r,
  output logic [N_WAYS-1:0]         ped_g,
  output logic [N_WAYS-1:0]         ped_r,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic [N_WAYS-1:0]         ped_pending
);

  localparam int WAY_W = $clog2(N_WAYS);
  localparam int TW    = timer_width(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC);
  localparam logic [N_WAYS-1:0] ONE_HOT0 = N_WAYS'(1);

  if (N_WAYS < 2 || N_WAYS > 8 || GREEN_CYC < 1 || YELLOW_CYC < 1 ||
      ALLRED_CYC < 1 || WALK_CYC < 1) begin : g_bad_param
    $error("traffic_ctrl_n: parameter out of legal range");
  end

  state_e              state_q, state_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [WAY_W-1:0]    nxt_q, nxt_d;
  logic [N_WAYS-1:0]   snap_q, snap_d;
  logic [N_WAYS-1:0]   pend_q, pend_d;
  logic [N_WAYS-1:0]   sig_g_q, sig_g_d;
  logic [N_WAYS-1:0]   sig_y_q, sig_y_d;
  logic [N_WAYS-1:0]   ped_g_q, ped_g_d;
  logic [TW-1:0]       load_val;
  logic                t_done;
  logic                adv;

  assign adv = en && t_done;

  phase_timer #(
    .W       (TW),
    .RST_VAL (TW'(ALLRED_CYC - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (adv),
    .en       (en),
    .load_val (load_val),
    .done     (t_done)
  );

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    nxt_d   = nxt_q;
    snap_d  = snap_q;
    pend_d  = pend_q | ped_req;
    if (adv) begin
      unique case (state_q)
        ALLRED: begin
          if (pend_q != '0) begin
            state_d = WALK;
            snap_d  = pend_q;
          end else begin
            state_d = GREEN;
            way_d   = nxt_q;
            nxt_d   = (nxt_q == WAY_W'(N_WAYS - 1)) ? '0 : nxt_q + 1'b1;
          end
        end
        GREEN:  state_d = YELLOW;
        YELLOW: state_d = ALLRED;
        WALK: begin
          state_d = GREEN;
          way_d   = nxt_q;
          nxt_d   = (nxt_q == WAY_W'(N_WAYS - 1)) ? '0 : nxt_q + 1'b1;
          // a request landing on the exit edge survives into the next WALK
          pend_d  = (pend_q & ~snap_q) | ped_req;
        end
      endcase
    end

    load_val = TW'(ALLRED_CYC - 1);
    unique case (state_d)
      ALLRED: load_val = TW'(ALLRED_CYC - 1);
      GREEN:  load_val = TW'(GREEN_CYC - 1);
      YELLOW: load_val = TW'(YELLOW_CYC - 1);
      WALK:   load_val = TW'(WALK_CYC - 1);
    endcase

    sig_g_d = '0;
    sig_y_d = '0;
    ped_g_d = '0;
    unique case (state_d)
      GREEN:  sig_g_d = ONE_HOT0 << way_d;
      YELLOW: sig_y_d = ONE_HOT0 << way_d;
      WALK:   ped_g_d = snap_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALLRED;
      way_q   <= '0;
      nxt_q   <= '0;
      snap_q  <= '0;
      pend_q  <= '0;
      sig_g_q <= '0;
      sig_y_q <= '0;
      ped_g_q <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      nxt_q   <= nxt_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      sig_g_q <= sig_g_d;
      sig_y_q <= sig_y_d;
      ped_g_q <= ped_g_d;
    end
  end

  assign sig_g       = sig_g_q;
  assign sig_y       = sig_y_q;
  assign sig_r       = ~(sig_g_q | sig_y_q);
  assign ped_g       = ped_g_q;
  assign ped_r       = ~ped_g_q;
  assign active_way  = way_q;
  assign ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench for traffic_ctrl_n: a default 4-way instance and a
// 2-way instance with unit durations, plus per-cycle lamp invariants.
module tb_traffic_ctrl_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] ped_req = '0;
  logic [1:0] ped_req2 = '0;

  logic [3:0] sig_g, sig_y, sig_r, ped_g, ped_r, ped_pending;
  logic [1:0] active_way;
  logic [1:0] sig_g2, sig_y2, sig_r2, ped_g2, ped_r2, ped_pending2;
  logic       active_way2;

  traffic_ctrl_n #(
    .N_WAYS(4), .GREEN_CYC(8), .YELLOW_CYC(3), .ALLRED_CYC(2), .WALK_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ped_req(ped_req),
    .sig_g(sig_g), .sig_y(sig_y), .sig_r(sig_r), .ped_g(ped_g), .ped_r(ped_r),
    .active_way(active_way), .ped_pending(ped_pending)
  );

  traffic_ctrl_n #(
    .N_WAYS(2), .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .WALK_CYC(1)
  ) dut2 (
    .clk(clk), .reset(reset), .en(en), .ped_req(ped_req2),
    .sig_g(sig_g2), .sig_y(sig_y2), .sig_r(sig_r2), .ped_g(ped_g2), .ped_r(ped_r2),
    .active_way(active_way2), .ped_pending(ped_pending2)
  );

  always #5 clk = ~clk;

  int unsigned tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int n_checks = 0;
  int n_err = 0;
  int unsigned base = 0;

  typedef struct {
    int unsigned t;
    int          which;
    string       name;
    logic [3:0]  g, y, pg, pend;
    logic [1:0]  way;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int which, input int c, input string name,
                      input logic [3:0] g, input logic [3:0] y, input logic [3:0] pg,
                      input logic [3:0] pend, input logic [1:0] way);
    exp_t e;
    e.t = base + c; e.which = which; e.name = name;
    e.g = g; e.y = y; e.pg = pg; e.pend = pend; e.way = way;
    sb.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_inv(input string name, input int n, input logic [3:0] g, input logic [3:0] y,
                           input logic [3:0] r, input logic [3:0] pg, input logic [3:0] pr);
    logic [3:0] m;
    logic ok;
    m  = 4'((1 << n) - 1);
    ok = ($countones(g | y) <= 1) && (r == (~(g | y) & m)) && (pr == (~pg & m)) &&
         ((pg == '0) || (r == m));
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s t=%0d: g=%b y=%b r=%b pg=%b pr=%b", name, tick, g, y, r, pg, pr);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ag, ay, apg, apend;
    logic [1:0] aw;
    check_inv("inv4", 4, sig_g, sig_y, sig_r, ped_g, ped_r);
    check_inv("inv2", 2, {2'b0, sig_g2}, {2'b0, sig_y2}, {2'b0, sig_r2}, {2'b0, ped_g2}, {2'b0, ped_r2});
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t == tick) begin
        if (sb[i].which == 0) begin
          ag = sig_g; ay = sig_y; apg = ped_g; apend = ped_pending; aw = active_way;
        end else begin
          ag = {2'b0, sig_g2}; ay = {2'b0, sig_y2}; apg = {2'b0, ped_g2};
          apend = {2'b0, ped_pending2}; aw = {1'b0, active_way2};
        end
        n_checks++;
        if (ag !== sb[i].g || ay !== sb[i].y || apg !== sb[i].pg ||
            apend !== sb[i].pend || aw !== sb[i].way) begin
          n_err++;
          $display("FAIL %s t=%0d: got g=%b y=%b pg=%b pend=%b way=%0d want g=%b y=%b pg=%b pend=%b way=%0d",
                   sb[i].name, tick, ag, ay, apg, apend, aw,
                   sb[i].g, sb[i].y, sb[i].pg, sb[i].pend, sb[i].way);
        end
        sb.delete(i);
      end else if (sb[i].t < tick) begin
        n_checks++;
        n_err++;
        $display("FAIL %s: expectation for t=%0d never sampled", sb[i].name, sb[i].t);
        sb.delete(i);
      end
    end
  end

  task automatic wait_to(input int c);
    while (tick < base + c) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name);
    check_val({name, "_g"},    {28'd0, sig_g}, 32'h0);
    check_val({name, "_y"},    {28'd0, sig_y}, 32'h0);
    check_val({name, "_r"},    {28'd0, sig_r}, 32'hF);
    check_val({name, "_pr"},   {28'd0, ped_r}, 32'hF);
    check_val({name, "_pg"},   {28'd0, ped_g}, 32'h0);
    check_val({name, "_pend"}, {28'd0, ped_pending}, 32'h0);
    check_val({name, "_way"},  {30'd0, active_way}, 32'h0);
    check_val({name, "_r2"},   {30'd0, sig_r2}, 32'h3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b1;
    ped_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = tick;
    check_reset_vals("rst");
  endtask

  initial begin
    // rotation without pedestrians; the 2-way unit-duration instance alongside
    do_reset();
    push(0, 1,  "A_ar_init", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 2,  "A_g0_rise", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 9,  "A_g0_last", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 10, "A_y0",      4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    push(0, 12, "A_y0_last", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    push(0, 13, "A_ar0",     4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 14, "A_ar0_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 15, "A_g1",      4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    push(0, 53, "A_ar3",     4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd3);
    push(0, 54, "A_g0_again",4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(1, 1,  "F_g0",      4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(1, 2,  "F_y0",      4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0);
    push(1, 3,  "F_ar",      4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(1, 4,  "F_g1",      4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    push(1, 5,  "F_y1",      4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd1);
    push(1, 6,  "F_ar1",     4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1);
    push(1, 7,  "F_g0b",     4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    wait_to(56);

    // pulse on crossing 1 in GREEN(0), then crossing 3 held on the WALK exit edge
    do_reset();
    push(0, 3,  "B_pre",     4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 4,  "B_latch",   4'b0001, 4'b0000, 4'b0000, 4'b0010, 2'd0);
    push(0, 9,  "B_g0_last", 4'b0001, 4'b0000, 4'b0000, 4'b0010, 2'd0);
    push(0, 10, "B_y0",      4'b0000, 4'b0001, 4'b0000, 4'b0010, 2'd0);
    push(0, 14, "B_ar",      4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd0);
    push(0, 15, "B_walk",    4'b0000, 4'b0000, 4'b0010, 4'b0010, 2'd0);
    push(0, 18, "B_walk_end",4'b0000, 4'b0000, 4'b0010, 4'b0010, 2'd0);
    push(0, 19, "C_g1_pend3",4'b0010, 4'b0000, 4'b0000, 4'b1000, 2'd1);
    push(0, 31, "C_ar",      4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd1);
    push(0, 32, "C_walk",    4'b0000, 4'b0000, 4'b1000, 4'b1000, 2'd1);
    push(0, 35, "C_walk_end",4'b0000, 4'b0000, 4'b1000, 4'b1000, 2'd1);
    push(0, 36, "C_g2",      4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd2);
    wait_to(3);  ped_req = 4'b0010;
    wait_to(4);  ped_req = 4'b0000;
    wait_to(18); ped_req = 4'b1000;
    wait_to(19); ped_req = 4'b0000;
    wait_to(37);

    // five frozen cycles inside YELLOW(2), request arriving during the freeze
    do_reset();
    push(0, 35, "D_g2_last", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd2);
    push(0, 36, "D_y2",      4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd2);
    push(0, 38, "D_frozen",  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd2);
    push(0, 39, "D_ped_frz", 4'b0000, 4'b0100, 4'b0000, 4'b0001, 2'd2);
    push(0, 41, "D_frz_end", 4'b0000, 4'b0100, 4'b0000, 4'b0001, 2'd2);
    push(0, 43, "D_y2_8th",  4'b0000, 4'b0100, 4'b0000, 4'b0001, 2'd2);
    push(0, 44, "D_ar",      4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd2);
    push(0, 46, "D_walk",    4'b0000, 4'b0000, 4'b0001, 4'b0001, 2'd2);
    push(0, 49, "D_walk_end",4'b0000, 4'b0000, 4'b0001, 4'b0001, 2'd2);
    push(0, 50, "D_g3",      4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'd3);
    wait_to(36); en = 1'b0;
    wait_to(38); ped_req = 4'b0001;
    wait_to(39); ped_req = 4'b0000;
    wait_to(41); en = 1'b1;
    wait_to(51);

    // asynchronous reset between edges in GREEN(2) with a pending request
    do_reset();
    push(0, 29, "E_g2",      4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd2);
    push(0, 31, "E_g2_pend", 4'b0100, 4'b0000, 4'b0000, 4'b0001, 2'd2);
    wait_to(29); ped_req = 4'b0001;
    wait_to(30); ped_req = 4'b0000;
    wait_to(31);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    base = tick;
    push(0, 1, "E_restart_ar", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    push(0, 2, "E_restart_g0", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0);
    wait_to(4);

    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
